// File: rtl/tblink_rpc_invoke_deframer.sv
// tblink_rpc_invoke_deframer
//   Reassembles TBLink RPC invocation frames (header + parameter words) from a
//   32-bit request stream, presents one invocation at a time to the target BFM,
//   and returns a two-word response frame for blocking calls or malformed frames.
// Ports:
//   clock, reset            : rising-edge clock, synchronous active-high reset
//   req_dat/valid/ready     : request word stream (in)
//   inv_*                   : invocation presented to the BFM (valid/ready)
//   done_valid/ready/retval : completion of a blocking invocation
//   rsp_dat/valid/ready     : response word stream (out)
//   err_count               : saturating count of malformed (oversized) frames
module tblink_rpc_invoke_deframer #(
  parameter int unsigned MAX_PARAMS = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [31:0]                      req_dat,
  input  logic                             req_valid,
  output logic                             req_ready,
  output logic                             inv_valid,
  input  logic                             inv_ready,
  output logic [7:0]                       inv_method,
  output logic [7:0]                       inv_call_id,
  output logic [3:0]                       inv_nparams,
  output logic                             inv_blocking,
  output logic [MAX_PARAMS*DATA_WIDTH-1:0] inv_params,
  input  logic                             done_valid,
  output logic                             done_ready,
  input  logic [31:0]                      done_retval,
  output logic [31:0]                      rsp_dat,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [15:0]                      err_count
);

  localparam int unsigned PW = MAX_PARAMS * DATA_WIDTH;

  typedef enum logic [2:0] {
    S_HDR, S_PARAMS, S_DISCARD, S_DISPATCH, S_WAIT_DONE, S_RSP_HDR, S_RSP_VAL
  } state_e;

  state_e        state_q, state_d;
  logic          req_ready_q, inv_valid_q, done_ready_q, rsp_valid_q;
  logic [7:0]    method_q, call_id_q;
  logic [3:0]    nparams_q, idx_q, remain_q;
  logic          blocking_q;
  logic [PW-1:0] params_q;
  logic [31:0]   retval_q, rsp_dat_q;
  logic [15:0]   err_count_q;

  // Header bits [31:21] carry nothing this stage uses.
  logic unused_hdr_bits;
  assign unused_hdr_bits = ^req_dat[31:21];

  // Next-state decode; handshakes qualified by the registered ready/valid flags.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HDR: begin
        if (req_valid && req_ready_q) begin
          if (req_dat[19:16] > 4'(MAX_PARAMS)) state_d = S_DISCARD;
          else if (req_dat[19:16] == 4'd0)     state_d = S_DISPATCH;
          else                                 state_d = S_PARAMS;
        end
      end
      S_PARAMS:    if (req_valid && req_ready_q && (idx_q == nparams_q - 4'd1)) state_d = S_DISPATCH;
      S_DISCARD:   if (req_valid && req_ready_q && (remain_q <= 4'd1)) state_d = S_RSP_HDR;
      S_DISPATCH:  if (inv_ready) state_d = blocking_q ? S_WAIT_DONE : S_HDR;
      S_WAIT_DONE: if (done_valid) state_d = S_RSP_HDR;
      S_RSP_HDR:   if (rsp_ready) state_d = S_RSP_VAL;
      S_RSP_VAL:   if (rsp_ready) state_d = S_HDR;
      default:     state_d = S_HDR;
    endcase
  end

  // State, handshake flags and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_HDR;
      req_ready_q  <= 1'b1;
      inv_valid_q  <= 1'b0;
      done_ready_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      method_q     <= '0;
      call_id_q    <= '0;
      nparams_q    <= '0;
      blocking_q   <= 1'b0;
      params_q     <= '0;
      idx_q        <= '0;
      remain_q     <= '0;
      retval_q     <= '0;
      rsp_dat_q    <= '0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= (state_d == S_HDR) || (state_d == S_PARAMS) || (state_d == S_DISCARD);
      inv_valid_q  <= (state_d == S_DISPATCH);
      done_ready_q <= (state_d == S_WAIT_DONE);
      rsp_valid_q  <= (state_d == S_RSP_HDR) || (state_d == S_RSP_VAL);

      case (state_q)
        S_HDR: begin
          if (req_valid && req_ready_q) begin
            method_q   <= req_dat[7:0];
            call_id_q  <= req_dat[15:8];
            nparams_q  <= req_dat[19:16];
            blocking_q <= req_dat[20];
            params_q   <= '0;
            idx_q      <= '0;
            remain_q   <= req_dat[19:16];
          end
        end
        S_PARAMS: begin
          if (req_valid && req_ready_q) begin
            for (int unsigned i = 0; i < MAX_PARAMS; i++) begin
              if (idx_q == 4'(i)) params_q[DATA_WIDTH*i +: DATA_WIDTH] <= req_dat;
            end
            idx_q <= idx_q + 4'd1;
          end
        end
        S_DISCARD: begin
          if (req_valid && req_ready_q) begin
            remain_q <= remain_q - 4'd1;
            // Last dropped word: stage the error response and bump the counter.
            if (remain_q <= 4'd1) begin
              rsp_dat_q <= {23'b0, 1'b1, call_id_q};
              retval_q  <= '0;
              if (err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
            end
          end
        end
        S_WAIT_DONE: begin
          if (done_valid) begin
            retval_q  <= done_retval;
            rsp_dat_q <= {23'b0, 1'b0, call_id_q};
          end
        end
        S_RSP_HDR: if (rsp_ready) rsp_dat_q <= retval_q;
        default: ;
      endcase
    end
  end

  assign req_ready    = req_ready_q;
  assign inv_valid    = inv_valid_q;
  assign done_ready   = done_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign inv_method   = method_q;
  assign inv_call_id  = call_id_q;
  assign inv_nparams  = nparams_q;
  assign inv_blocking = blocking_q;
  assign inv_params   = params_q;
  assign rsp_dat      = rsp_dat_q;
  assign err_count    = err_count_q;

endmodule

// File: tb/tb_tblink_rpc_invoke_deframer.sv
// tb_tblink_rpc_invoke_deframer
//   Directed scoreboard bench: expected invocations and response words are
//   queued as stimulus is driven and popped when the DUT presents them.
module tb_tblink_rpc_invoke_deframer;

  localparam int unsigned MP = 4;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [31:0]    req_dat = '0;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic           inv_valid;
  logic           inv_ready = 1'b0;
  logic [7:0]     inv_method;
  logic [7:0]     inv_call_id;
  logic [3:0]     inv_nparams;
  logic           inv_blocking;
  logic [MP*32-1:0] inv_params;
  logic           done_valid = 1'b0;
  logic           done_ready;
  logic [31:0]    done_retval = '0;
  logic [31:0]    rsp_dat;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [15:0]    err_count;

  tblink_rpc_invoke_deframer #(.MAX_PARAMS(MP), .DATA_WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .req_dat(req_dat), .req_valid(req_valid), .req_ready(req_ready),
    .inv_valid(inv_valid), .inv_ready(inv_ready),
    .inv_method(inv_method), .inv_call_id(inv_call_id),
    .inv_nparams(inv_nparams), .inv_blocking(inv_blocking),
    .inv_params(inv_params),
    .done_valid(done_valid), .done_ready(done_ready), .done_retval(done_retval),
    .rsp_dat(rsp_dat), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .err_count(err_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0]   m;
    logic [7:0]   c;
    logic [3:0]   n;
    logic         b;
    logic [127:0] p;
  } inv_t;

  inv_t        inv_q[$];
  logic [31:0] rsp_q[$];
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one word at a negedge, hold until accepted; returns at the next negedge.
  task automatic send_word(input logic [31:0] w);
    int n = 0;
    req_dat = w;
    req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready) chk("req_accept_timeout", 128'(req_ready), 128'(1));
    else begin
      @(posedge clock);
      @(negedge clock);
    end
    req_valid = 1'b0;
  endtask

  // Wait for an invocation, compare against the scoreboard, optionally stall it.
  task automatic expect_inv(input int hold);
    int   n = 0;
    inv_t e;
    while (!inv_valid && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("inv_seen", 128'(inv_valid), 128'(1));
    if (!inv_valid) return;
    chk("inv_expected", 128'(inv_q.size() != 0), 128'(1));
    if (inv_q.size() == 0) return;
    e = inv_q.pop_front();
    chk("inv_method", 128'(inv_method), 128'(e.m));
    chk("inv_call_id", 128'(inv_call_id), 128'(e.c));
    chk("inv_nparams", 128'(inv_nparams), 128'(e.n));
    chk("inv_blocking", 128'(inv_blocking), 128'(e.b));
    chk("inv_params", 128'(inv_params), e.p);
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      chk("inv_hold_valid", 128'(inv_valid), 128'(1));
      chk("inv_hold_method", 128'(inv_method), 128'(e.m));
      chk("inv_hold_params", 128'(inv_params), e.p);
      chk("inv_hold_req_ready", 128'(req_ready), 128'(0));
    end
    inv_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    inv_ready = 1'b0;
  endtask

  // Complete a blocking call; the response frame is queued as it is driven.
  task automatic complete(input logic [31:0] r, input logic [7:0] call);
    int n = 0;
    while (!done_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("done_ready_seen", 128'(done_ready), 128'(1));
    rsp_q.push_back({24'h0, call});
    rsp_q.push_back(r);
    done_valid = 1'b1;
    done_retval = r;
    @(posedge clock);
    @(negedge clock);
    done_valid = 1'b0;
    done_retval = '0;
  endtask

  // Drain a two-word response; optional stall with rsp_ready low per word.
  task automatic expect_rsp(input bit stall);
    logic [31:0] e;
    for (int w = 0; w < 2; w++) begin
      int n = 0;
      while (!rsp_valid && n < 50) begin
        @(negedge clock);
        n++;
      end
      chk("rsp_seen", 128'(rsp_valid), 128'(1));
      chk("rsp_expected", 128'(rsp_q.size() != 0), 128'(1));
      if (!rsp_valid || rsp_q.size() == 0) return;
      e = rsp_q.pop_front();
      chk("rsp_dat", 128'(rsp_dat), 128'(e));
      if (stall) begin
        for (int i = 0; i < 2; i++) begin
          rsp_ready = 1'b0;
          @(negedge clock);
          chk("rsp_hold_valid", 128'(rsp_valid), 128'(1));
          chk("rsp_hold_dat", 128'(rsp_dat), 128'(e));
          chk("rsp_hold_req_ready", 128'(req_ready), 128'(0));
        end
      end
      rsp_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      rsp_ready = 1'b0;
      if (w == 0) chk("rsp_mid_req_ready", 128'(req_ready), 128'(0));
    end
    chk("rsp_end_req_ready", 128'(req_ready), 128'(1));
    chk("rsp_end_valid", 128'(rsp_valid), 128'(0));
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("rst_req_ready", 128'(req_ready), 128'(1));
    chk("rst_inv_valid", 128'(inv_valid), 128'(0));
    chk("rst_done_ready", 128'(done_ready), 128'(0));
    chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("rst_rsp_dat", 128'(rsp_dat), 128'(0));
    chk("rst_inv_method", 128'(inv_method), 128'(0));
    chk("rst_inv_params", 128'(inv_params), 128'(0));
    chk("rst_err_count", 128'(err_count), 128'(0));

    // Non-blocking, 2 params: inv_valid 3 cycles after the header
    inv_q.push_back('{m: 8'h05, c: 8'h03, n: 4'd2, b: 1'b0, p: {64'h0, 32'hB, 32'hA}});
    send_word(32'h0002_0305);
    send_word(32'h0000_000A);
    chk("t1_no_early_inv", 128'(inv_valid), 128'(0));
    send_word(32'h0000_000B);
    chk("t1_latency", 128'(inv_valid), 128'(1));
    expect_inv(0);
    chk("t1_req_ready_h1", 128'(req_ready), 128'(1));
    repeat (3) begin
      @(negedge clock);
      chk("t1_no_rsp", 128'(rsp_valid), 128'(0));
    end

    // Blocking, 0 params, BFM returns 0xDEADBEEF
    inv_q.push_back('{m: 8'h01, c: 8'h07, n: 4'd0, b: 1'b1, p: 128'h0});
    send_word(32'h0010_0701);
    chk("t2_latency", 128'(inv_valid), 128'(1));
    expect_inv(0);
    chk("t2_wait_req_ready", 128'(req_ready), 128'(0));
    chk("t2_wait_done_ready", 128'(done_ready), 128'(1));
    complete(32'hDEAD_BEEF, 8'h07);
    chk("t2_rsp_latency", 128'(rsp_valid), 128'(1));
    expect_rsp(1'b0);

    // Malformed: nparams=7 > MAX_PARAMS, error response with call id 0x42
    send_word(32'h0007_4209);
    for (int i = 0; i < 7; i++) begin
      chk("t3_req_ready", 128'(req_ready), 128'(1));
      send_word(32'h1000_0000 + 32'(i));
      chk("t3_no_inv", 128'(inv_valid), 128'(0));
    end
    rsp_q.push_back(32'h0000_0142);
    rsp_q.push_back(32'h0000_0000);
    chk("t3_rsp_latency", 128'(rsp_valid), 128'(1));
    expect_rsp(1'b0);
    chk("t3_err_count", 128'(err_count), 128'(1));

    // Back-pressure: inv_ready low 5 cycles with a pending request word, rsp stalled
    inv_q.push_back('{m: 8'h22, c: 8'h11, n: 4'd3, b: 1'b1,
                      p: {32'h0, 32'h0000_0333, 32'h0000_0222, 32'h0000_0111}});
    send_word(32'h0013_1122);
    send_word(32'h0000_0111);
    send_word(32'h0000_0222);
    send_word(32'h0000_0333);
    req_dat = 32'h0000_0504;
    req_valid = 1'b1;
    expect_inv(5);
    chk("t4_wait_req_ready", 128'(req_ready), 128'(0));
    req_valid = 1'b0;
    complete(32'h1234_5678, 8'h11);
    expect_rsp(1'b1);
    inv_q.push_back('{m: 8'h04, c: 8'h05, n: 4'd0, b: 1'b0, p: 128'h0});
    send_word(32'h0000_0504);
    expect_inv(0);

    // Spurious done_valid in HDR is ignored
    done_valid = 1'b1;
    done_retval = 32'hBAD0_BAD0;
    repeat (3) begin
      @(negedge clock);
      chk("t5_done_ready", 128'(done_ready), 128'(0));
      chk("t5_no_rsp", 128'(rsp_valid), 128'(0));
      chk("t5_req_ready", 128'(req_ready), 128'(1));
    end
    done_valid = 1'b0;
    done_retval = '0;

    // Reset after 1 of 3 params: partial frame lost, next frame dispatched
    send_word(32'h0003_0909);
    send_word(32'h0000_0999);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("t6_req_ready", 128'(req_ready), 128'(1));
    chk("t6_inv_valid", 128'(inv_valid), 128'(0));
    chk("t6_err_count", 128'(err_count), 128'(0));
    inv_q.push_back('{m: 8'h0C, c: 8'h0B, n: 4'd1, b: 1'b0, p: {96'h0, 32'hCAFE_F00D}});
    send_word(32'h0001_0B0C);
    send_word(32'hCAFE_F00D);
    chk("t6_latency", 128'(inv_valid), 128'(1));
    expect_inv(0);
    repeat (2) begin
      @(negedge clock);
      chk("t6_no_rsp", 128'(rsp_valid), 128'(0));
    end
    chk("t6_err_after", 128'(err_count), 128'(0));

    chk("end_inv_q_empty", 128'(inv_q.size()), 128'(0));
    chk("end_rsp_q_empty", 128'(rsp_q.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
